// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, index width helper, default byte width.
// Latency: none (package only).
// Backpressure: none (package only).
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SEND      = 2'b01,
        WAIT_DONE = 2'b10
    } state_t;

    localparam int DEF_DATA_W = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set request bit strictly after last_grant, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; valid is simply the OR of the request vector.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;

    // Duplicate the request vector and keep only the window last_grant+1 .. last_grant+NUM_REQ.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int j = 0; j < 2 * NUM_REQ; j++) begin
            masked[j] = dbl[j] && (j > int'(last_grant)) && (j <= int'(last_grant) + NUM_REQ);
        end
    end

    // Priority scan of the window; descending loop so the lowest set position wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int j = 2 * NUM_REQ - 1; j >= 0; j--) begin
            if (masked[j]) begin
                valid  = 1'b1;
                winner = (j >= NUM_REQ) ? IDX_W'(j - NUM_REQ) : IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin arbitration and per-requester ack.
// Latency: req sampled -> tx_send one cycle later; ack one cycle after tx_busy is sampled low.
// Backpressure: requesters hold req/data until ack; tx_busy high in IDLE blocks new grants.
// Optional: define UART_TX_ARBITER_TIMEOUT_EN to abort a SEND that never sees tx_busy (err pulse, no ack).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        l_ready_reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id,
    output logic                        active,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_send,
    input  logic                        tx_busy,
    output logic                        err
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] win;
    logic             win_vld;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (win),
        .valid      (win_vld)
    );

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    logic [CNT_W-1:0] busy_cnt;
    logic             timeout;
    assign timeout = (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1));
`else
    assign err = 1'b0;
`endif

    // Arbitration FSM: grant, hold the byte on the transmitter pins, wait out busy, then ack.
    always_ff @(posedge clk or posedge l_ready_reset) begin
        if (l_ready_reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_id   <= '0;
            tx_data    <= '0;
            tx_send    <= 1'b0;
            active     <= 1'b0;
            ack        <= '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            err        <= 1'b0;
            busy_cnt   <= '0;
`endif
        end else begin
            ack <= '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A transmitter still busy from before a reset must finish before we hand it a byte.
                    if (win_vld && !tx_busy) begin
                        tx_data  <= req_data[int'(win)*DATA_W +: DATA_W];
                        grant_id <= win;
                        tx_send  <= 1'b1;
                        active   <= 1'b1;
                        state    <= SEND;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                        busy_cnt <= '0;
`endif
                    end
                end
                SEND: begin
                    if (tx_busy) begin
                        tx_send <= 1'b0;
                        state   <= WAIT_DONE;
                    end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    // Give up on this byte but advance the pointer so the others are not starved.
                    else if (timeout) begin
                        tx_send    <= 1'b0;
                        active     <= 1'b0;
                        err        <= 1'b1;
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        ack[grant_id] <= 1'b1;
                        last_grant    <= grant_id;
                        active        <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple busy-handshake transmitter model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    ack;
    logic [1:0]       grant_id;
    logic             active;
    logic [DW-1:0]    tx_data;
    logic             tx_send;
    logic             tx_busy = 1'b0;
    logic             err;

    int checks = 0;
    int errors = 0;

    // Transmitter model controls
    bit   m_en    = 1'b0;
    logic m_force = 1'b0;
    int   m_hold  = 5;
    int   m_state = 0;
    int   m_cnt   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_W       (DW),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk           (clk),
        .l_ready_reset (rst),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .grant_id      (grant_id),
        .active        (active),
        .tx_data       (tx_data),
        .tx_send       (tx_send),
        .tx_busy       (tx_busy),
        .err           (err)
    );

    // Transmitter model: busy rises 3 cycles after send is seen, stays high m_hold cycles.
    always @(negedge clk) begin
        if (!m_en) begin
            tx_busy = m_force;
            m_state = 0;
        end else begin
            case (m_state)
                0: if (tx_send && !tx_busy) begin m_state = 1; m_cnt = 3; end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin tx_busy = 1'b1; m_state = 2; m_cnt = m_hold; end
                end
                default: begin
                    m_cnt--;
                    if (m_cnt == 0) begin tx_busy = 1'b0; m_state = 0; end
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        m_en    = 1'b0;
        m_force = 1'b0;
        m_hold  = 5;
        repeat (3) step();
        #2 rst = 1'b0;
        m_en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_data = '0;
        #2;
        checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_single();
        int send_n = 0, bad_data = 0, ack2_n = 0, other_ack = 0, ack_cyc = -1;
        do_reset();
        m_hold   = 100;
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        req      = 4'b0100;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (tx_send) send_n++;
            if (active && tx_data !== 8'hA5) bad_data++;
            if (ack[2]) begin ack2_n++; ack_cyc = c; req = '0; end
            if ((ack & 4'b1011) != 0) other_ack++;
        end
        checks++; if (send_n != 4) begin errors++; $display("FAIL single_send_cycles: got %0d want 4", send_n); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL single_tx_data: %0d cycles not A5, want 0", bad_data); end
        checks++; if (ack2_n != 1) begin errors++; $display("FAIL single_ack2_count: got %0d want 1", ack2_n); end
        checks++; if (other_ack != 0) begin errors++; $display("FAIL single_other_ack: got %0d want 0", other_ack); end
        checks++; if (ack_cyc != 105) begin errors++; $display("FAIL single_ack_cycle: got %0d want 105", ack_cyc); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
        m_hold = 5;
    endtask

    task automatic test_back_to_back();
        int order[$];
        int exp_o[5] = '{0, 1, 2, 3, 0};
        int exp_a[4] = '{2, 1, 1, 1};
        int acks[4]  = '{0, 0, 0, 0};
        int total = 0, last_ack = -1, gap_bad = 0, data_bad = 0;
        logic prev_send = 1'b0;
        logic [7:0] exp_d;
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req      = 4'b1111;
        for (int c = 1; c <= 400 && total < 5; c++) begin
            step();
            if (tx_send && !prev_send) begin
                order.push_back(int'(grant_id));
                exp_d = 8'h10 + {6'b0, grant_id};
                if (tx_data !== exp_d) data_bad++;
                if (last_ack > 0 && c != last_ack + 1) gap_bad++;
            end
            prev_send = tx_send;
            for (int i = 0; i < 4; i++) if (ack[i]) begin acks[i]++; total++; end
            if (ack != 0) last_ack = c;
        end
        req = '0;
        checks++; if (order.size() != 5) begin errors++; $display("FAIL rr_grant_count: got %0d want 5", order.size()); end
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            checks++;
            if (order[i] != exp_o[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_o[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acks[i] != exp_a[i]) begin errors++; $display("FAIL rr_ack_count[%0d]: got %0d want %0d", i, acks[i], exp_a[i]); end
        end
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL rr_gap: %0d grants not one cycle after ack, want 0", gap_bad); end
        checks++; if (data_bad != 0) begin errors++; $display("FAIL rr_data: %0d grants with wrong byte, want 0", data_bad); end
    endtask

    task automatic test_withdrawal();
        bit found;
        do_reset();
        req_data = {8'h13, 8'h12, 8'hB1, 8'hC0};
        req      = 4'b0010;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            if (active && !tx_send && tx_busy) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL wd_wait_done: got not reached want reached"); end
        req = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin step(); if (ack != 0) found = 1'b1; end
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL wd_ack1: got %b want 0010", ack); end
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin step(); if (tx_send) found = 1'b1; end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL wd_next_grant: got %0d want 0", grant_id); end
        checks++; if (tx_data !== 8'hC0) begin errors++; $display("FAIL wd_next_data: got %h want C0", tx_data); end
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin step(); if (ack != 0) begin found = 1'b1; req = '0; end end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wd_ack0: got %b want 0001", ack); end
    endtask

    task automatic test_reset_mid();
        bit found;
        int ack_n = 0;
        req_data = {8'h33, 8'h22, 8'h11, 8'h5A};
        req      = 4'b0100;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            if (active && !tx_send && tx_busy) found = 1'b1;
        end
        checks++; if (!found || grant_id !== 2'd2) begin errors++; $display("FAIL rm_wait_done: got found=%0d grant=%0d want found=1 grant=2", found, grant_id); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx_send !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL rm_async_ctrl: got send=%b active=%b want 0 0", tx_send, active); end
        checks++; if (grant_id !== 2'd0 || tx_data !== 8'h00) begin errors++; $display("FAIL rm_async_data: got grant=%0d data=%h want 0 00", grant_id, tx_data); end
        req = 4'b1001;
        repeat (2) begin step(); if (ack != 0) ack_n++; end
        #2 rst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            if (ack != 0) ack_n++;
            if (tx_send) found = 1'b1;
        end
        checks++; if (ack_n != 0) begin errors++; $display("FAIL rm_no_ack: got %0d acks want 0", ack_n); end
        checks++; if (!found || grant_id !== 2'd0 || tx_data !== 8'h5A) begin
            errors++; $display("FAIL rm_first_grant: got found=%0d grant=%0d data=%h want 1 0 5A", found, grant_id, tx_data);
        end
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin step(); if (ack != 0) begin found = 1'b1; req = '0; end end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rm_ack0: got %b want 0001", ack); end
    endtask

    task automatic test_busy_at_reset();
        bit found;
        int early = 0;
        rst = 1'b1; m_en = 1'b0; m_force = 1'b1;
        req_data = {8'h00, 8'h00, 8'h00, 8'h77};
        req = 4'b0001;
        repeat (2) step();
        #2 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin step(); if (tx_send) early++; end
        checks++; if (early != 0) begin errors++; $display("FAIL bz_blocked: got %0d send cycles want 0", early); end
        m_force = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (!tx_busy) begin found = 1'b1; m_en = 1'b1; end
        end
        checks++; if (!found || tx_send !== 1'b1) begin errors++; $display("FAIL bz_release: got found=%0d send=%b want 1 1", found, tx_send); end
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin step(); if (ack != 0) begin found = 1'b1; req = '0; end end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL bz_ack0: got %b want 0001", ack); end
    endtask

    task automatic test_timeout();
        int send_n = 0, err_n = 0, err_cyc = -1, ack_n = 0;
        do_reset();
        m_en = 1'b0; m_force = 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        req_data = {8'h00, 8'h00, 8'hE1, 8'hE0};
        req = 4'b0011;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (tx_send) send_n++;
            if (err) begin err_n++; err_cyc = c; end
            if (ack != 0) ack_n++;
        end
        checks++; if (send_n != 16) begin errors++; $display("FAIL to_send_cycles: got %0d want 16", send_n); end
        checks++; if (err_n != 1 || err_cyc != 17) begin errors++; $display("FAIL to_err: got n=%0d cyc=%0d want 1 17", err_n, err_cyc); end
        checks++; if (ack_n != 0) begin errors++; $display("FAIL to_no_ack: got %0d want 0", ack_n); end
        step();
        checks++; if (tx_send !== 1'b1 || grant_id !== 2'd1 || tx_data !== 8'hE1) begin
            errors++; $display("FAIL to_next: got send=%b grant=%0d data=%h want 1 1 E1", tx_send, grant_id, tx_data);
        end
`else
        req_data = {8'h00, 8'h00, 8'h00, 8'hE0};
        req = 4'b0001;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (tx_send) send_n++;
            if (err) err_n++;
            if (ack != 0) ack_n++;
        end
        checks++; if (send_n != 40 || active !== 1'b1) begin errors++; $display("FAIL nto_stuck: got send=%0d active=%b want 40 1", send_n, active); end
        checks++; if (err_n != 0 || ack_n != 0) begin errors++; $display("FAIL nto_quiet: got err=%0d ack=%0d want 0 0", err_n, ack_n); end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_withdrawal();
        test_reset_mid();
        test_busy_at_reset();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
